if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the architectural PC register and the IF/ID pipeline register.
- Drives the fetch address to the instruction memory and latches the returned word, its PC and PC+4 into the D stage.
- Consumes the next-PC/redirect and clear outputs of the next-PC unit and the hazard unit's stall; detects fetch faults and halts fetch.

---
 rtl/if_stage.sv | 124 ++++++++++++
 tb/tb_if_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and halts fetch
// permanently (until reset) on a misaligned or out-of-range fetch address.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000,
  parameter int unsigned IM_DEPTH = 4096,
  parameter logic [31:0] NOP_WORD = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        clear,
  input  logic [31:0] im_instr,
  output logic [31:0] im_addr,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc4_D,
  output logic        valid_D,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [31:0] LastPc = RESET_PC + 32'(IM_DEPTH * 4) - 32'd4;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pc4d_q, pc4d_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] count_q, count_d;
  logic [31:0] pc_plus4;
  logic        bad;

  assign pc_plus4 = pc_q + 32'd4;
  assign bad      = (pc_q[1:0] != 2'b00) || (pc_q < RESET_PC) || (pc_q > LastPc);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pcd_d      = pcd_q;
    pc4d_d     = pc4d_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    count_d    = count_q;
    unique case (state_q)
      StRun: begin
        // A stall freezes everything, including the fault check.
        if (!stall) begin
          if (bad) begin
            state_d    = StHalt;
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            instr_d    = NOP_WORD;
            valid_d    = 1'b0;
            pcd_d      = pc_q;
            pc4d_d     = pc_plus4;
          end else begin
            if (clear) begin
              instr_d = NOP_WORD;
              valid_d = 1'b0;
            end else begin
              instr_d = im_instr;
              valid_d = 1'b1;
              count_d = count_q + 32'd1;
            end
            pcd_d  = pc_q;
            pc4d_d = pc_plus4;
            pc_d   = redirect ? redirect_pc : pc_plus4;
          end
        end
      end
      StHalt: begin
        instr_d = NOP_WORD;
        valid_d = 1'b0;
        pcd_d   = pc_q;
        pc4d_d  = pc_plus4;
      end
      default: state_d = StHalt;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_WORD;
      pcd_q      <= RESET_PC;
      pc4d_q     <= RESET_PC + 32'd4;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      fault_pc_q <= 32'd0;
      count_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pcd_q      <= pcd_d;
      pc4d_q     <= pc4d_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
      count_q    <= count_d;
    end
  end

  assign im_addr     = pc_q;
  assign instr_D     = instr_q;
  assign pc_D        = pcd_q;
  assign pc4_D       = pc4d_q;
  assign valid_D     = valid_q;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic
// checked against a behavioural fetch model.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        clear = 1'b0;
  logic [31:0] im_instr;
  logic [31:0] im_addr, instr_D, pc_D, pc4_D, fault_pc, fetch_count;
  logic        valid_D, fault;

  int n_cmp = 0;
  int n_fail = 0;

  // Behavioural model of architectural state.
  logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_fpc, m_cnt;
  logic        m_valid, m_fault, m_halt;

  always #5 clk = ~clk;

  // Instruction memory content is a fixed function of the address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  assign im_instr = imem(im_addr);

  if_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .clear      (clear),
    .im_instr   (im_instr),
    .im_addr    (im_addr),
    .instr_D    (instr_D),
    .pc_D       (pc_D),
    .pc4_D      (pc4_D),
    .valid_D    (valid_D),
    .fault      (fault),
    .fault_pc   (fault_pc),
    .fetch_count(fetch_count)
  );

  function automatic bit is_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h3000 + 4 * 4096 - 4);
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_instr = 32'd0; m_pcd = 32'h3000; m_pc4d = 32'h3004;
    m_valid = 1'b0; m_fault = 1'b0; m_fpc = 32'd0; m_cnt = 32'd0; m_halt = 1'b0;
  endtask

  task automatic model_bubble();
    m_instr = 32'd0; m_valid = 1'b0; m_pcd = m_pc; m_pc4d = m_pc + 4;
  endtask

  task automatic model_step();
    if (m_halt) begin
      model_bubble();
    end else if (!stall) begin
      if (is_bad(m_pc)) begin
        m_halt = 1'b1; m_fault = 1'b1; m_fpc = m_pc;
        model_bubble();
      end else begin
        if (clear) model_bubble();
        else begin
          m_instr = imem(m_pc); m_valid = 1'b1; m_pcd = m_pc; m_pc4d = m_pc + 4;
          m_cnt = m_cnt + 1;
        end
        m_pc = redirect ? redirect_pc : m_pc + 4;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    stall = 1'b0; redirect = 1'b0; clear = 1'b0; redirect_pc = 32'd0;
    model_reset();
    #2;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (im_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_pc: got %h want %h", im_addr, 32'h3000); end
    if (pc_D !== 32'h3000) begin n_fail++; $display("FAIL reset_pc_D: got %h want %h", pc_D, 32'h3000); end
    if (pc4_D !== 32'h3004) begin n_fail++; $display("FAIL reset_pc4_D: got %h want %h", pc4_D, 32'h3004); end
    if (valid_D !== 1'b0 || instr_D !== 32'd0) begin n_fail++; $display("FAIL reset_ifid: got v=%b i=%h want v=0 i=0", valid_D, instr_D); end
    if (fault !== 1'b0 || fault_pc !== 32'd0) begin n_fail++; $display("FAIL reset_fault: got %b/%h want 0/0", fault, fault_pc); end
    if (fetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp += 3;
      if (pc_D !== 32'h3000 + 4 * i) begin n_fail++; $display("FAIL seq_pc_D[%0d]: got %h want %h", i, pc_D, 32'h3000 + 4 * i); end
      if (instr_D !== imem(32'h3000 + 4 * i) || valid_D !== 1'b1) begin n_fail++; $display("FAIL seq_instr[%0d]: got %h/%b want %h/1", i, instr_D, valid_D, imem(32'h3000 + 4 * i)); end
      if (pc4_D !== 32'h3004 + 4 * i) begin n_fail++; $display("FAIL seq_pc4_D[%0d]: got %h want %h", i, pc4_D, 32'h3004 + 4 * i); end
    end
    n_cmp++;
    if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL seq_count: got %0d want 4", fetch_count); end
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    held_pc = m_pc;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3400; clear = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp += 2;
      if (im_addr !== held_pc) begin n_fail++; $display("FAIL stall_pc[%0d]: got %h want %h", i, im_addr, held_pc); end
      if (pc_D !== m_pcd || instr_D !== m_instr || fetch_count !== m_cnt) begin
        n_fail++; $display("FAIL stall_ifid[%0d]: got %h/%h/%0d want %h/%h/%0d", i, pc_D, instr_D, fetch_count, m_pcd, m_instr, m_cnt);
      end
    end
    stall = 1'b0; redirect = 1'b0; clear = 1'b0;
    tick();
    n_cmp += 2;
    if (pc_D !== held_pc || valid_D !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got %h/%b want %h/1", pc_D, valid_D, held_pc); end
    if (im_addr !== held_pc + 4) begin n_fail++; $display("FAIL stall_resume_pc: got %h want %h", im_addr, held_pc + 4); end
  endtask

  task automatic test_redirect();
    logic [31:0] cur;
    cur = m_pc;
    redirect = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect = 1'b0;
    n_cmp += 2;
    if (pc_D !== cur || valid_D !== 1'b1) begin n_fail++; $display("FAIL redir_latch: got %h/%b want %h/1", pc_D, valid_D, cur); end
    if (im_addr !== 32'h3100) begin n_fail++; $display("FAIL redir_pc: got %h want %h", im_addr, 32'h3100); end
    tick();
    n_cmp++;
    if (pc_D !== 32'h3100 || instr_D !== imem(32'h3100)) begin n_fail++; $display("FAIL redir_target: got %h/%h want %h/%h", pc_D, instr_D, 32'h3100, imem(32'h3100)); end
    cur = m_pc;
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3200;
    tick();
    stall = 1'b0; redirect = 1'b0;
    n_cmp++;
    if (im_addr !== cur) begin n_fail++; $display("FAIL redir_stalled: got %h want %h", im_addr, cur); end
  endtask

  task automatic test_clear();
    logic [31:0] cnt, cur;
    cnt = m_cnt; cur = m_pc;
    clear = 1'b1;
    tick();
    n_cmp += 3;
    if (valid_D !== 1'b0 || instr_D !== 32'd0) begin n_fail++; $display("FAIL clear_bubble: got %b/%h want 0/0", valid_D, instr_D); end
    if (im_addr !== cur + 4) begin n_fail++; $display("FAIL clear_pc: got %h want %h", im_addr, cur + 4); end
    if (fetch_count !== cnt) begin n_fail++; $display("FAIL clear_count: got %0d want %0d", fetch_count, cnt); end
    redirect = 1'b1; redirect_pc = 32'h3020;
    tick();
    clear = 1'b0; redirect = 1'b0;
    n_cmp++;
    if (valid_D !== 1'b0 || im_addr !== 32'h3020) begin n_fail++; $display("FAIL clear_redir: got %b/%h want 0/%h", valid_D, im_addr, 32'h3020); end
  endtask

  task automatic test_fault();
    logic [31:0] cnt;
    redirect = 1'b1; redirect_pc = 32'h3002;
    tick();
    redirect = 1'b0;
    n_cmp++;
    if (fault !== 1'b0 || im_addr !== 32'h3002) begin n_fail++; $display("FAIL fault_early: got %b/%h want 0/%h", fault, im_addr, 32'h3002); end
    tick();
    cnt = m_cnt;
    n_cmp += 2;
    if (fault !== 1'b1 || fault_pc !== 32'h3002) begin n_fail++; $display("FAIL fault_raise: got %b/%h want 1/%h", fault, fault_pc, 32'h3002); end
    if (valid_D !== 1'b0 || pc_D !== 32'h3002) begin n_fail++; $display("FAIL fault_bubble: got %b/%h want 0/%h", valid_D, pc_D, 32'h3002); end
    for (int i = 0; i < 4; i++) begin
      redirect = 1'b1; redirect_pc = 32'h3100; clear = i[0]; stall = i[1];
      tick();
      n_cmp++;
      if (im_addr !== 32'h3002 || valid_D !== 1'b0 || fault !== 1'b1 || fetch_count !== cnt) begin
        n_fail++; $display("FAIL halt_hold[%0d]: got %h/%b/%b/%0d want %h/0/1/%0d", i, im_addr, valid_D, fault, fetch_count, 32'h3002, cnt);
      end
    end
    redirect = 1'b0; clear = 1'b0; stall = 1'b0;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    stall = 1'b1;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    n_cmp += 2;
    if (im_addr !== 32'h3000 || fault !== 1'b0) begin n_fail++; $display("FAIL async_reset_pc: got %h/%b want %h/0", im_addr, fault, 32'h3000); end
    if (valid_D !== 1'b0 || fetch_count !== 32'd0 || fault_pc !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_state: got %b/%0d/%h want 0/0/0", valid_D, fetch_count, fault_pc);
    end
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
  endtask

  task automatic test_bounds();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h6FFC;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++;
    if (fault !== 1'b0 || pc_D !== 32'h6FFC || valid_D !== 1'b1) begin n_fail++; $display("FAIL bound_last: got %b/%h/%b want 0/%h/1", fault, pc_D, valid_D, 32'h6FFC); end
    tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'h7000) begin n_fail++; $display("FAIL bound_high: got %b/%h want 1/%h", fault, fault_pc, 32'h7000); end
    do_reset();
    redirect = 1'b1; redirect_pc = 32'h2FFC;
    tick();
    redirect = 1'b0;
    tick();
    n_cmp++;
    if (fault !== 1'b1 || fault_pc !== 32'h2FFC) begin n_fail++; $display("FAIL bound_low: got %b/%h want 1/%h", fault, fault_pc, 32'h2FFC); end
  endtask

  task automatic test_random();
    int halted;
    do_reset();
    halted = 0;
    for (int i = 0; i < 400; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 6) == 0);
      redirect = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 40) == 0) redirect_pc = $urandom;
      else redirect_pc = 32'h3000 + ($urandom_range(0, 4095) * 4);
      tick();
      n_cmp += 4;
      if (im_addr !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, im_addr, m_pc); end
      if (instr_D !== m_instr || valid_D !== m_valid) begin n_fail++; $display("FAIL rnd_instr[%0d]: got %h/%b want %h/%b", i, instr_D, valid_D, m_instr, m_valid); end
      if (pc_D !== m_pcd || pc4_D !== m_pc4d) begin n_fail++; $display("FAIL rnd_pcd[%0d]: got %h/%h want %h/%h", i, pc_D, pc4_D, m_pcd, m_pc4d); end
      if (fault !== m_fault || fault_pc !== m_fpc || fetch_count !== m_cnt) begin
        n_fail++; $display("FAIL rnd_status[%0d]: got %b/%h/%0d want %b/%h/%0d", i, fault, fault_pc, fetch_count, m_fault, m_fpc, m_cnt);
      end
      if (m_halt) halted++;
      if (halted > 5) begin
        do_reset();
        halted = 0;
      end
    end
    stall = 1'b0; clear = 1'b0; redirect = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_clear();
    test_fault();
    test_async_reset();
    test_bounds();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
